// File: rtl/snd_pkg.sv
// Shared types and constants for the OPM output mixer.
package snd_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic [3:0]         vol_t;

  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;
  localparam int VOL_SHIFT  = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SAT
  } mix_state_t;

endpackage

// File: rtl/snd_sat.sv
// Removes the vol/8 gain scaling from an accumulator and clamps it to a 16-bit sample.
module snd_sat
  import snd_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] acc,
  output sample_t                 sample,
  output logic                    clipped
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(SAMPLE_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(SAMPLE_MIN);

  logic signed [ACC_W-1:0] shifted;

  // Arithmetic shift floors toward negative infinity before the clamp.
  always_comb begin
    shifted = acc >>> VOL_SHIFT;
    sample  = shifted[15:0];
    clipped = 1'b0;
    if (shifted > HI) begin
      sample  = sample_t'(SAMPLE_MAX);
      clipped = 1'b1;
    end else if (shifted < LO) begin
      sample  = sample_t'(SAMPLE_MIN);
      clipped = 1'b1;
    end
  end

endmodule

// File: rtl/snd_opm_mixer.sv
// Stereo mixer for several OPM instances: per-instance gain, serial MAC, 16-bit saturation.
// Optional SND_MIX_CLIP_STAT_EN adds a saturating clip_cnt output.
module snd_opm_mixer
  import snd_pkg::*;
#(
  parameter int COUNT = 3,
  parameter int ACC_W = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT-1:0]       in_valid,
  input  logic [COUNT-1:0][15:0] in_L,
  input  logic [COUNT-1:0][15:0] in_R,
  input  logic [COUNT-1:0]       ch_en,
  input  logic [COUNT-1:0][3:0]  vol,
  input  logic                   tick,
  output sample_t                out_L,
  output sample_t                out_R,
  output logic                   out_valid,
`ifdef SND_MIX_CLIP_STAT_EN
  output logic [15:0]            clip_cnt,
`endif
  output logic                   busy
);

  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  mix_state_t state, next_state;
  logic start;

  logic [COUNT-1:0][15:0] hold_L, hold_R, shadow_L, shadow_R;
  logic signed [ACC_W-1:0] acc_L, acc_R;
  logic [IDX_W-1:0] idx;
  logic pending;

  logic signed [20:0] prod_L, prod_R;
  sample_t sat_L, sat_R;
  logic clip_L, clip_R;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (tick || pending) begin
          start      = 1'b1;
          next_state = ACCUM;
        end
      end
      ACCUM:   if (idx == LAST_IDX) next_state = SAT;
      SAT:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Gain is applied as an integer multiply by vol; the /8 happens at saturation.
  always_comb begin
    prod_L = '0;
    prod_R = '0;
    if (ch_en[idx]) begin
      prod_L = $signed(shadow_L[idx]) * $signed({1'b0, vol[idx]});
      prod_R = $signed(shadow_R[idx]) * $signed({1'b0, vol[idx]});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_L    <= '0;
      hold_R    <= '0;
      shadow_L  <= '0;
      shadow_R  <= '0;
      acc_L     <= '0;
      acc_R     <= '0;
      idx       <= '0;
      pending   <= 1'b0;
      out_L     <= '0;
      out_R     <= '0;
      out_valid <= 1'b0;
    end else begin
      for (int i = 0; i < COUNT; i++) begin
        if (in_valid[i]) begin
          hold_L[i] <= in_L[i];
          hold_R[i] <= in_R[i];
        end
      end

      if (start) begin
        shadow_L <= hold_L;
        shadow_R <= hold_R;
        acc_L    <= '0;
        acc_R    <= '0;
        idx      <= '0;
      end else if (state == ACCUM) begin
        acc_L <= acc_L + ACC_W'(prod_L);
        acc_R <= acc_R + ACC_W'(prod_R);
        idx   <= idx + IDX_W'(1);
      end

      // One-deep request queue: a tick arriving mid-mix is remembered, extras are dropped.
      if (state != IDLE && tick) pending <= 1'b1;
      else if (start)            pending <= 1'b0;

      out_valid <= (state == SAT);
      if (state == SAT) begin
        out_L <= sat_L;
        out_R <= sat_R;
      end
    end
  end

  snd_sat #(.ACC_W(ACC_W)) u_sat_L (.acc(acc_L), .sample(sat_L), .clipped(clip_L));
  snd_sat #(.ACC_W(ACC_W)) u_sat_R (.acc(acc_R), .sample(sat_R), .clipped(clip_R));

`ifdef SND_MIX_CLIP_STAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) clip_cnt <= '0;
    else if (state == SAT && (clip_L || clip_R) && clip_cnt != 16'hFFFF)
      clip_cnt <= clip_cnt + 16'd1;
  end
`else
  logic unused_clip;
  assign unused_clip = clip_L ^ clip_R;
`endif

endmodule
